// File: rtl/proc_pkg.sv
// Shared types and constants for the interrupt controller slice.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        FIRE    = 2'd2,
        SERVICE = 2'd3
    } irq_state_t;

    // Default source indices on the processor's interrupt inputs.
    localparam int IRQ_KEY = 0;
    localparam int IRQ_ETH = 1;

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous request, followed by a
// rising-edge detector on the synchronised level.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the raw level through the chain and remember the last synchronised level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source sync/edge detect, pending bits, round-robin
// grant, and a single fetch pulse followed by a service window held until rti/rsi.
module irq_ctrl
    import proc_pkg::*;
#(
    parameter  int NUM_SRC     = 2,
    parameter  int SYNC_STAGES = 2,
    parameter  int DATA_W      = 32,
    localparam int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        irq_raw,
    input  logic [NUM_SRC-1:0]        irq_en,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      stall,
    input  logic                      rti,
    input  logic                      rsi,
    output logic                      interrupt,
    output logic                      in_service,
    output logic [ID_W-1:0]           irq_id,
    output logic [DATA_W-1:0]         irq_data,
    output logic [NUM_SRC-1:0]        pending
);

    logic [NUM_SRC-1:0] edge_s;
    logic [NUM_SRC-1:0] grant_clr;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    pick_idx;
    logic               grant_vld;

    irq_state_t         state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [DATA_W-1:0]  irq_data_q, irq_data_d;
    logic               interrupt_q, interrupt_d;
    logic               in_service_q, in_service_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (irq_raw[i]),
            .edge_o (edge_s[i])
        );
    end

    // Round-robin picker: first pending source at or after rr_q, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = {ID_W{1'b0}};
        pick_idx  = {ID_W{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            pick_idx = ID_W'((int'(rr_q) + k) % NUM_SRC);
            if (!grant_vld && pending_q[pick_idx]) begin
                grant_vld = 1'b1;
                grant_id  = pick_idx;
            end else begin
                grant_vld = grant_vld;
            end
        end
    end

    // Service FSM; grant bookkeeping happens only on the IDLE->ARM transition.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        irq_id_d   = irq_id_q;
        irq_data_d = irq_data_q;
        grant_clr  = {NUM_SRC{1'b0}};
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d             = ARM;
                    irq_id_d            = grant_id;
                    irq_data_d          = src_data[int'(grant_id)*DATA_W +: DATA_W];
                    grant_clr[grant_id] = 1'b1;
                    rr_d = (int'(grant_id) == NUM_SRC - 1) ? {ID_W{1'b0}} : grant_id + 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                if (!stall) begin
                    state_d = FIRE;
                end else begin
                    state_d = ARM;
                end
            end
            FIRE: begin
                state_d = SERVICE;
            end
            SERVICE: begin
                if (rti || rsi) begin
                    state_d = IDLE;
                end else begin
                    state_d = SERVICE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        interrupt_d  = (state_d == FIRE);
        in_service_d = (state_d == FIRE) || (state_d == SERVICE);
    end

    // A fresh edge on the grant cycle re-sets the bit (set beats clear); disabling drops it.
    always_comb begin
        pending_d = ((pending_q & ~grant_clr) | (edge_s & irq_en)) & irq_en;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= {NUM_SRC{1'b0}};
            rr_q         <= {ID_W{1'b0}};
            irq_id_q     <= {ID_W{1'b0}};
            irq_data_q   <= {DATA_W{1'b0}};
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            rr_q         <= rr_d;
            irq_id_q     <= irq_id_d;
            irq_data_q   <= irq_data_d;
            interrupt_q  <= interrupt_d;
            in_service_q <= in_service_d;
        end
    end

    assign interrupt  = interrupt_q;
    assign in_service = in_service_q;
    assign irq_id     = irq_id_q;
    assign irq_data   = irq_data_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl with two sources.
module tb_irq_ctrl;
    import proc_pkg::*;

    localparam logic [31:0] D0 = 32'hDEAD_0001;
    localparam logic [31:0] D1 = 32'hBEEF_0002;

    logic        clk;
    logic        rst_n;
    logic [1:0]  irq_raw;
    logic [1:0]  irq_en;
    logic [63:0] src_data;
    logic        stall;
    logic        rti;
    logic        rsi;
    logic        interrupt;
    logic        in_service;
    logic [0:0]  irq_id;
    logic [31:0] irq_data;
    logic [1:0]  pending;

    int errors = 0;
    int checks = 0;

    irq_ctrl #(.NUM_SRC(2), .SYNC_STAGES(2), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_raw    (irq_raw),
        .irq_en     (irq_en),
        .src_data   (src_data),
        .stall      (stall),
        .rti        (rti),
        .rsi        (rsi),
        .interrupt  (interrupt),
        .in_service (in_service),
        .irq_id     (irq_id),
        .irq_data   (irq_data),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_raw(input logic [1:0] mask);
        irq_raw = mask;
        tick();
        irq_raw = 2'b00;
    endtask

    // Expect the pulse exactly n edges from now, quiet before it.
    task automatic wait_fire(input logic [31:0] exp_id, input logic [31:0] exp_data, input int n);
        for (int i = 1; i < n; i++) begin
            tick();
            chk("pre_pulse", {31'd0, interrupt}, 32'd0);
        end
        tick();
        chk("pulse", {31'd0, interrupt}, 32'd1);
        chk("pulse_svc", {31'd0, in_service}, 32'd1);
        chk("irq_id", {31'd0, irq_id}, exp_id);
        chk("irq_data", irq_data, exp_data);
    endtask

    // From the FIRE cycle: check pulse width, then end service with rti or rsi.
    task automatic end_service(input logic use_rsi);
        tick();
        chk("pulse_width", {31'd0, interrupt}, 32'd0);
        chk("svc_hold", {31'd0, in_service}, 32'd1);
        rti = ~use_rsi;
        rsi = use_rsi;
        tick();
        chk("svc_end", {31'd0, in_service}, 32'd0);
        rti = 1'b0;
        rsi = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        irq_raw  = 2'b00;
        irq_en   = 2'b11;
        src_data = {D1, D0};
        stall    = 1'b0;
        rti      = 1'b0;
        rsi      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_interrupt", {31'd0, interrupt}, 32'd0);
        chk("rst_in_service", {31'd0, in_service}, 32'd0);
        chk("rst_irq_id", {31'd0, irq_id}, 32'd0);
        chk("rst_irq_data", irq_data, 32'd0);
        chk("rst_pending", {30'd0, pending}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single request on the keypad source: pulse 5 edges after the raw edge.
        pulse_raw(2'b01);
        tick();
        chk("t1_pend_e2", {30'd0, pending}, 32'd0);
        tick();
        chk("t1_pend_e3", {30'd0, pending}, 32'd1);
        tick();
        chk("t1_pend_grant", {30'd0, pending}, 32'd0);
        chk("t1_no_pulse_e4", {31'd0, interrupt}, 32'd0);
        src_data[31:0] = 32'h1234_5678;
        wait_fire(IRQ_KEY, D0, 1);
        src_data[31:0] = D0;
        end_service(1'b0);
        tick();
        chk("t1_no_repeat", {31'd0, interrupt}, 32'd0);

        // Both sources together from rr pointer 0: order 0 then 1, twice.
        do_reset();
        pulse_raw(2'b11);
        wait_fire(IRQ_KEY, D0, 4);
        chk("t2_pend_left", {30'd0, pending}, 32'd2);
        end_service(1'b0);
        wait_fire(IRQ_ETH, D1, 2);
        end_service(1'b1);
        pulse_raw(2'b11);
        wait_fire(IRQ_KEY, D0, 4);
        end_service(1'b0);
        wait_fire(IRQ_ETH, D1, 2);
        chk("t2_data_hold", irq_data, D1);
        end_service(1'b0);
        chk("t2_id_hold", {31'd0, irq_id}, 32'd1);

        // Stall held while armed: no pulse until stall falls.
        stall = 1'b1;
        pulse_raw(2'b01);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t3_stalled", {31'd0, interrupt}, 32'd0);
        end
        chk("t3_pend_granted", {30'd0, pending}, 32'd0);
        stall = 1'b0;
        wait_fire(IRQ_KEY, D0, 1);
        end_service(1'b1);

        // New request during service waits for the handler to return.
        pulse_raw(2'b01);
        wait_fire(IRQ_KEY, D0, 4);
        pulse_raw(2'b10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_nest", {31'd0, interrupt}, 32'd0);
        end
        chk("t4_pending", {30'd0, pending}, 32'd2);
        chk("t4_in_service", {31'd0, in_service}, 32'd1);
        rti = 1'b1;
        tick();
        rti = 1'b0;
        chk("t4_svc_end", {31'd0, in_service}, 32'd0);
        wait_fire(IRQ_ETH, D1, 2);
        end_service(1'b0);

        // Disabled source never becomes pending.
        irq_en = 2'b01;
        pulse_raw(2'b10);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_masked_irq", {31'd0, interrupt}, 32'd0);
        end
        chk("t5_masked_pend", {30'd0, pending}, 32'd0);
        pulse_raw(2'b01);
        wait_fire(IRQ_KEY, D0, 4);
        end_service(1'b0);
        irq_en = 2'b11;

        // New edge arriving on the grant cycle keeps the source pending.
        pulse_raw(2'b01);
        wait_fire(IRQ_KEY, D0, 4);
        irq_raw = 2'b01;
        tick();
        irq_raw = 2'b00;
        tick();
        tick();
        chk("t7_pend_in_svc", {30'd0, pending}, 32'd1);
        irq_raw = 2'b01;
        tick();
        irq_raw = 2'b00;
        rti = 1'b1;
        tick();
        rti = 1'b0;
        chk("t7_svc_end", {31'd0, in_service}, 32'd0);
        tick();
        chk("t7_set_wins", {30'd0, pending}, 32'd1);
        wait_fire(IRQ_KEY, D0, 1);
        chk("t7_pend_kept", {30'd0, pending}, 32'd1);
        end_service(1'b0);
        tick();
        chk("t7_regrant", {30'd0, pending}, 32'd0);
        wait_fire(IRQ_KEY, D0, 1);
        end_service(1'b0);

        // Dropping the enable clears a waiting pending bit.
        pulse_raw(2'b01);
        wait_fire(IRQ_KEY, D0, 4);
        pulse_raw(2'b10);
        tick();
        tick();
        chk("t8_pend_set", {30'd0, pending}, 32'd2);
        irq_en = 2'b01;
        tick();
        chk("t8_en_clear", {30'd0, pending}, 32'd0);
        irq_en = 2'b11;
        rti = 1'b1;
        tick();
        rti = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t8_no_irq", {31'd0, interrupt}, 32'd0);
        end

        // Asynchronous reset in the middle of a service window.
        pulse_raw(2'b01);
        wait_fire(IRQ_KEY, D0, 4);
        pulse_raw(2'b10);
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        chk("t6_pend_pre", {30'd0, pending}, 32'd2);
        chk("t6_svc_pre", {31'd0, in_service}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_irq", {31'd0, interrupt}, 32'd0);
        chk("t6_rst_svc", {31'd0, in_service}, 32'd0);
        chk("t6_rst_id", {31'd0, irq_id}, 32'd0);
        chk("t6_rst_data", irq_data, 32'd0);
        chk("t6_rst_pend", {30'd0, pending}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_quiet", {29'd0, interrupt, pending}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
